// File: rtl/ucounter_pkg.sv
// ucounter_pkg: shared constants and next-state action encoding for ucounter_n.
package ucounter_pkg;
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;
    localparam logic WRAP = 1'b0;
    localparam logic STOP = 1'b1;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STEP_W = 4;

    typedef enum logic [2:0] {HOLD, SET, LOAD, INC, DEC} action_e;
endpackage

// File: rtl/ucounter_bound_calc.sv
// ucounter_bound_calc: combinational step result with bound compare and wrap/stop select.
module ucounter_bound_calc
    import ucounter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STEP_W = DEF_STEP_W
) (
    input  logic [WIDTH-1:0]  cnt_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              updown_i,
    input  logic              wrapstop_i,
    input  logic [WIDTH-1:0]  min_i,
    input  logic [WIDTH-1:0]  max_i,
    output logic [WIDTH-1:0]  nxt_o,
    output logic              ovf_o,
    output logic              udf_o
);
    logic [WIDTH:0] step_x, sum, diff;
    logic           stop;

    assign step_x = (WIDTH+1)'(step_i);
    assign sum    = {1'b0, cnt_i} + step_x;
    assign diff   = {1'b0, cnt_i} - step_x;
    assign stop   = wrapstop_i == STOP;

    // diff is signed so a step below zero still compares as below min
    assign ovf_o = (updown_i == UP) && (sum > {1'b0, max_i});
    assign udf_o = (updown_i == DOWN) && ($signed(diff) < $signed({1'b0, min_i}));

    assign nxt_o = ovf_o ? (stop ? max_i : min_i) :
                   udf_o ? (stop ? min_i : max_i) :
                   (updown_i == UP) ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
endmodule

// File: rtl/ucounter_n.sv
// ucounter_n: bounded up/down counter with wrap/stop, event pulses and sticky flags.
// Define UCOUNTER_PRESCALE_EN to take one step per PRESCALE enabled cycles.
module ucounter_n
    import ucounter_pkg::*;
#(
    parameter int              WIDTH    = DEF_WIDTH,
    parameter int              STEP_W   = DEF_STEP_W,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int              PRESCALE = 4
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              en,
    input  logic              set,
    input  logic              load,
    input  logic [WIDTH-1:0]  preld_val,
    input  logic              updown,
    input  logic              wrapstop,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  dcount,
    output logic              overflow,
    output logic              underflow,
    output logic              ovf_sticky,
    output logic              udf_sticky,
    output logic              cfg_err
);
    if (WIDTH < 2 || WIDTH > 32 || PRESCALE < 2 || PRESCALE > 256) begin : g_bad_cfg
        $error("ucounter_n: parameter out of range");
    end

    action_e          act;
    logic             step_cyc;
    logic [WIDTH-1:0] calc_nxt;
    logic             calc_ovf, calc_udf;
    logic [WIDTH-1:0] dcount_q, dcount_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             ovs_q, ovs_d, uds_q, uds_d;

    assign cfg_err = min_val > max_val;

`ifdef UCOUNTER_PRESCALE_EN
    localparam int PH_W = $clog2(PRESCALE);
    logic [PH_W-1:0] phase_q, phase_d;

    assign step_cyc = phase_q == PH_W'(PRESCALE - 1);
    assign phase_d  = (set || load) ? '0 :
                      !en           ? phase_q :
                      step_cyc      ? '0 : phase_q + 1'b1;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            phase_q <= '0;
        else
            phase_q <= phase_d;
    end
`else
    assign step_cyc = 1'b1;
`endif

    ucounter_bound_calc #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_calc (
        .cnt_i      (dcount_q),
        .step_i     (step),
        .updown_i   (updown),
        .wrapstop_i (wrapstop),
        .min_i      (min_val),
        .max_i      (max_val),
        .nxt_o      (calc_nxt),
        .ovf_o      (calc_ovf),
        .udf_o      (calc_udf)
    );

    always_comb begin
        act = HOLD;
        if (set)
            act = SET;
        else if (load)
            act = LOAD;
        else if (en && step_cyc && step != '0 && !cfg_err)
            act = (updown == UP) ? INC : DEC;
    end

    assign dcount_d = (act == SET)                ? max_val :
                      (act == LOAD)               ? preld_val :
                      (act == INC || act == DEC)  ? calc_nxt : dcount_q;
    assign ovf_d    = (act == INC) && calc_ovf;
    assign udf_d    = (act == DEC) && calc_udf;
    // a fresh event outranks a same-edge clear
    assign ovs_d    = ovf_d | (ovs_q & ~clr_flags);
    assign uds_d    = udf_d | (uds_q & ~clr_flags);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            dcount_q <= RST_VAL;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ovs_q    <= 1'b0;
            uds_q    <= 1'b0;
        end else begin
            dcount_q <= dcount_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ovs_q    <= ovs_d;
            uds_q    <= uds_d;
        end
    end

    assign dcount     = dcount_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;
    assign ovf_sticky = ovs_q;
    assign udf_sticky = uds_q;
endmodule

// File: tb/tb_ucounter_n.sv
// tb_ucounter_n: scoreboard bench for ucounter_n driven by a behavioural reference model.
module tb_ucounter_n;
    localparam int W  = 8;
    localparam int SW = 4;
    localparam int P  = 4;

    logic          clk = 1'b0, areset = 1'b1, en = 1'b0, set = 1'b0, load = 1'b0;
    logic          updown = 1'b1, wrapstop = 1'b0, clr_flags = 1'b0;
    logic [W-1:0]  preld_val = '0, min_val = '0, max_val = 8'hFF;
    logic [SW-1:0] step = '0;
    logic [W-1:0]  dcount;
    logic          overflow, underflow, ovf_sticky, udf_sticky, cfg_err;

    ucounter_n #(.WIDTH(W), .STEP_W(SW), .RST_VAL('0), .PRESCALE(P)) dut (
        .clk(clk), .areset(areset), .en(en), .set(set), .load(load),
        .preld_val(preld_val), .updown(updown), .wrapstop(wrapstop), .step(step),
        .min_val(min_val), .max_val(max_val), .clr_flags(clr_flags),
        .dcount(dcount), .overflow(overflow), .underflow(underflow),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         o, u, os, us;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];
    int    vectors = 0, miscompares = 0;
    int    m_cnt;
    logic  m_o, m_u, m_os, m_us;
`ifdef UCOUNTER_PRESCALE_EN
    int    m_ph;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_o = 0; m_u = 0; m_os = 0; m_us = 0;
`ifdef UCOUNTER_PRESCALE_EN
        m_ph = 0;
`endif
    endtask

    task automatic model_step();
        int   s;
        logic fire;
        m_o = 0;
        m_u = 0;
        if (set) begin
            m_cnt = int'(max_val);
`ifdef UCOUNTER_PRESCALE_EN
            m_ph = 0;
`endif
        end else if (load) begin
            m_cnt = int'(preld_val);
`ifdef UCOUNTER_PRESCALE_EN
            m_ph = 0;
`endif
        end else begin
            fire = en;
`ifdef UCOUNTER_PRESCALE_EN
            if (en) begin
                fire = (m_ph == P - 1);
                m_ph = (m_ph + 1) % P;
            end
`endif
            if (fire && step != 0 && min_val <= max_val) begin
                if (updown) begin
                    s = m_cnt + int'(step);
                    if (s > int'(max_val)) begin
                        m_o = 1;
                        m_cnt = wrapstop ? int'(max_val) : int'(min_val);
                    end else m_cnt = s;
                end else begin
                    s = m_cnt - int'(step);
                    if (s < int'(min_val)) begin
                        m_u = 1;
                        m_cnt = wrapstop ? int'(min_val) : int'(max_val);
                    end else m_cnt = s;
                end
            end
        end
        m_os = m_o | (m_os & ~clr_flags);
        m_us = m_u | (m_us & ~clr_flags);
    endtask

    task automatic tick(input string tag);
        exp_t  e;
        string t;
        model_step();
        e.cnt = W'(m_cnt);
        e.o = m_o; e.u = m_u; e.os = m_os; e.us = m_us;
        sb.push_back(e);
        sb_tag.push_back(tag);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        t = sb_tag.pop_front();
        check({t, ".dcount"}, 32'(dcount), 32'(e.cnt));
        check({t, ".ovf"}, 32'(overflow), 32'(e.o));
        check({t, ".udf"}, 32'(underflow), 32'(e.u));
        check({t, ".ovs"}, 32'(ovf_sticky), 32'(e.os));
        check({t, ".uds"}, 32'(udf_sticky), 32'(e.us));
    endtask

    initial begin
        #12;
        check("rst.dcount", 32'(dcount), 0);
        check("rst.ovf", 32'(overflow), 0);
        check("rst.ovs", 32'(ovf_sticky), 0);
        check("rst.cfg_err", 32'(cfg_err), 0);
        areset = 1'b0;
        model_reset();

        load = 1; preld_val = 8'hF8;
        tick("t1_load");
        load = 0; en = 1; step = 1; updown = 1;
        repeat (7) tick("t1_up");
        check("t1_ff", 32'(dcount), 32'hFF);
        tick("t1_wrap");
        check("t1_wrap_cnt", 32'(dcount), 0);
        check("t1_wrap_ovf", 32'(overflow), 1);
        en = 0;
        tick("t1_idle");
        check("t1_ovf_drop", 32'(overflow), 0);

        min_val = 10; max_val = 20; wrapstop = 1; load = 1; preld_val = 18;
        tick("t2_load");
        load = 0; en = 1; step = 3;
        tick("t2_up");
        tick("t2_hold");
        check("t2_hold_cnt", 32'(dcount), 20);
        check("t2_hold_ovf", 32'(overflow), 1);
        updown = 0; step = 7;
        tick("t2_dn");
        tick("t2_dn_sat");
        check("t2_sat_cnt", 32'(dcount), 10);
        check("t2_sat_udf", 32'(underflow), 1);

        min_val = 5; max_val = 9; wrapstop = 0; load = 1; preld_val = 5; en = 0;
        tick("t3_load");
        load = 0; en = 1; step = 1; updown = 0;
        tick("t3_wrap");
        check("t3_wrap_cnt", 32'(dcount), 9);
        repeat (4) tick("t3_dn");
        check("t3_end", 32'(dcount), 5);

        min_val = 0; max_val = 200; updown = 1; set = 1; load = 1; preld_val = 3;
        tick("t4_set");
        check("t4_set_cnt", 32'(dcount), 200);
        set = 0;
        tick("t4_load");
        check("t4_load_cnt", 32'(dcount), 3);

        max_val = 8'hFF; load = 1; preld_val = 8'hFF; en = 0;
        tick("t5_load");
        load = 0; en = 1; clr_flags = 1;
        tick("t5_clr_evt");
        check("t5_sticky_win", 32'(ovf_sticky), 1);
        en = 0;
        tick("t5_clr");
        check("t5_sticky_clr", 32'(ovf_sticky), 0);
        clr_flags = 0; min_val = 50; max_val = 40; #1;
        check("t5_cfg_err", 32'(cfg_err), 1);
        en = 1;
        repeat (2) tick("t5_cfg_hold");
        set = 1;
        tick("t5_cfg_set");
        set = 0; min_val = 0; max_val = 8'hFF; #1;
        check("t5_cfg_ok", 32'(cfg_err), 0);

        load = 1; preld_val = 0; en = 0;
        tick("t6_load0");
        load = 0; en = 1; updown = 0; step = 1;
        tick("t6_udf");
        load = 1; preld_val = 8'h7E;
        tick("t6_load");
        load = 0; updown = 1;
        tick("t6_up");
        check("t6_7f", 32'(dcount), 32'h7F);
        #4 areset = 1;
        #1;
        check("t6_rst_cnt", 32'(dcount), 0);
        check("t6_rst_uds", 32'(udf_sticky), 0);
        check("t6_rst_ovf", 32'(overflow), 0);
        #1 areset = 0;
        model_reset();
        tick("t6_resume");

`ifdef UCOUNTER_PRESCALE_EN
        load = 1; preld_val = 0;
        tick("t7_load");
        load = 0;
        repeat (8) tick("t7_pre");
        check("t7_two_steps", 32'(dcount), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
